// File: rtl/matrix_scan_ctrl.sv
// Double-buffered 8x8 frame store and scan sequencer feeding the row/col decoder.
// Build option: define BLANKING_EN to blank pix during the first cycle of every dwell period.
module matrix_scan_ctrl #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_en,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic       wr_data,
    input  logic       frame_swap,
    output logic [5:0] add,
    output logic       pix,
    output logic       frame_start,
    output logic       swap_done
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);
    localparam logic [5:0] ADD_LAST = 6'd63;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  add_q, add_d;
    logic        pix_q, pix_d;
    logic        frame_start_q, frame_start_d;
    logic        swap_done_q, swap_done_d;
    logic        sel_q, sel_d;
    logic        pending_q, pending_d;
    logic [63:0] buf0_q, buf0_d;
    logic [63:0] buf1_q, buf1_d;

    logic        run;
    logic        wrap;
    logic        apply;
    logic [63:0] front_d;

    // NOTE: every signal assigned in a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (scan_en)  state_d = SCAN;
            SCAN:    if (!scan_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The next state decides what this edge does, so entering or leaving SCAN costs no cycle.
    assign run = (state_d == SCAN);

    always_comb begin
        cnt_d = '0;
        add_d = add_q;
        wrap  = 1'b0;
        if (run) begin
            if (cnt_q == CNT_LAST) begin
                add_d = add_q + 6'd1;
                wrap  = (add_q == ADD_LAST);
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        apply     = pending_q && (run ? wrap : 1'b1);
        sel_d     = sel_q ^ apply;
        pending_d = apply ? 1'b0 : (pending_q | frame_swap);
    end

    // Writes always target the back buffer as it stands before this edge, even on a swap edge.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (wr_en) begin
            if (sel_q) begin
                buf0_d[wr_addr] = wr_data;
            end else begin
                buf1_d[wr_addr] = wr_data;
            end
        end
    end

    always_comb begin
        front_d       = sel_d ? buf1_q : buf0_q;
        frame_start_d = wrap;
        swap_done_d   = apply;
`ifdef BLANKING_EN
        pix_d = run && (cnt_d != 8'd0) && front_d[add_d];
`else
        pix_d = run && front_d[add_d];
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the frame buffers are plain flops rather than a RAM, so reset can clear them in one edge.
            state_q       <= IDLE;
            cnt_q         <= '0;
            add_q         <= '0;
            pix_q         <= 1'b0;
            frame_start_q <= 1'b0;
            swap_done_q   <= 1'b0;
            sel_q         <= 1'b0;
            pending_q     <= 1'b0;
            buf0_q        <= '0;
            buf1_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            add_q         <= add_d;
            pix_q         <= pix_d;
            frame_start_q <= frame_start_d;
            swap_done_q   <= swap_done_d;
            sel_q         <= sel_d;
            pending_q     <= pending_d;
            buf0_q        <= buf0_d;
            buf1_q        <= buf1_d;
        end
    end

    assign add         = add_q;
    assign pix         = pix_q;
    assign frame_start = frame_start_q;
    assign swap_done   = swap_done_q;

endmodule
